// File: rtl/keypad_pkg.sv
// Shared keypad constants: scan codes, FSM encodings and key-event classification.
package keypad_pkg;

    localparam logic [8:0] SC_ESC      = 9'h076;
    localparam logic [8:0] SC_ENTER    = 9'h05A;
    localparam logic [8:0] SC_KP_ENTER = 9'h15A;
    localparam logic [8:0] SC_PLUS     = 9'h079;
    localparam logic [8:0] SC_BKSP     = 9'h066;

    // Translator output for keys that carry no decimal digit.
    localparam logic [3:0] DIGIT_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_ENT_A = 2'd0,
        ST_ENT_B = 2'd1,
        ST_RES   = 2'd2,
        ST_ILL   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_ESC,
        EV_ENTER,
        EV_PLUS,
        EV_BKSP,
        EV_DIGIT
    } event_e;

    // Ordered checks: a command code wins even if the translator also reports a digit.
    function automatic event_e classify(input logic [8:0] code, input logic [3:0] digit);
        if (code == SC_ESC)                               return EV_ESC;
        if (code == SC_ENTER || code == SC_KP_ENTER)      return EV_ENTER;
        if (code == SC_PLUS)                              return EV_PLUS;
        if (code == SC_BKSP)                              return EV_BKSP;
        if (!code[8] && digit != DIGIT_NONE && digit <= 4'd9) return EV_DIGIT;
        return EV_NONE;
    endfunction

endpackage

// File: rtl/bcd_adder.sv
// Combinational N-digit ripple BCD adder; result has one extra digit for the final carry.
module bcd_adder #(
    parameter int N = 2
) (
    input  logic [4*N-1:0]     a_i,
    input  logic [4*N-1:0]     b_i,
    output logic [4*(N+1)-1:0] sum_o
);

    logic [N:0] carry;
    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < N; gi++) begin : g_digit
        logic [4:0] raw;
        assign raw             = {1'b0, a_i[4*gi +: 4]} + {1'b0, b_i[4*gi +: 4]} + {4'd0, carry[gi]};
        assign carry[gi+1]     = (raw > 5'd9);
        assign sum_o[4*gi +: 4] = carry[gi+1] ? 4'(raw + 5'd6) : raw[3:0];
    end

    assign sum_o[4*N +: 4] = {3'd0, carry[N]};

endmodule

// File: rtl/keypad_entry.sv
// Collects keypad digits into two BCD operands and registers their sum on Enter.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int N = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [8:0]         key_code,
    input  logic [3:0]         key_digit,
    output logic [4*N-1:0]     digits_a,
    output logic [4*N-1:0]     digits_b,
    output logic [4*(N+1)-1:0] sum_bcd,
    output logic [1:0]         state,
    output logic               result_valid
);

    localparam int CW = $clog2(N + 1);

    state_e               state_q;
    logic [4*N-1:0]       a_q, b_q;
    logic [CW-1:0]        cnt_a_q, cnt_b_q;
    logic [4*(N+1)-1:0]   sum_q, sum_d;
    logic                 rv_q;
    event_e               ev;

    assign ev = key_valid ? classify(key_code, key_digit) : EV_NONE;

    bcd_adder #(.N(N)) u_add (
        .a_i   (a_q),
        .b_i   (b_q),
        .sum_o (sum_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ENT_A;
            a_q     <= '0;
            b_q     <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            sum_q   <= '0;
            rv_q    <= 1'b0;
        end else if (ev == EV_ESC || state_q == ST_ILL) begin
            state_q <= ST_ENT_A;
            a_q     <= '0;
            b_q     <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            sum_q   <= '0;
            rv_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_ENT_A: begin
                    case (ev)
                        EV_DIGIT: if (cnt_a_q < CW'(N)) begin
                            a_q     <= (a_q << 4) | (4*N)'(key_digit);
                            cnt_a_q <= cnt_a_q + 1'b1;
                        end
                        EV_BKSP: if (cnt_a_q != '0) begin
                            a_q     <= a_q >> 4;
                            cnt_a_q <= cnt_a_q - 1'b1;
                        end
                        EV_PLUS: state_q <= ST_ENT_B;
                        default: ;
                    endcase
                end
                ST_ENT_B: begin
                    case (ev)
                        EV_DIGIT: if (cnt_b_q < CW'(N)) begin
                            b_q     <= (b_q << 4) | (4*N)'(key_digit);
                            cnt_b_q <= cnt_b_q + 1'b1;
                        end
                        EV_BKSP: if (cnt_b_q != '0) begin
                            b_q     <= b_q >> 4;
                            cnt_b_q <= cnt_b_q - 1'b1;
                        end
                        EV_ENTER: begin
                            sum_q   <= sum_d;
                            state_q <= ST_RES;
                            rv_q    <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_RES: begin
                    // A digit starts a fresh calculation with that digit as A.
                    if (ev == EV_DIGIT) begin
                        a_q     <= (4*N)'(key_digit);
                        cnt_a_q <= CW'(1);
                        b_q     <= '0;
                        cnt_b_q <= '0;
                        sum_q   <= '0;
                        state_q <= ST_ENT_A;
                        rv_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign digits_a     = a_q;
    assign digits_b     = b_q;
    assign sum_bcd      = sum_q;
    assign state        = state_q;
    assign result_valid = rv_q;

endmodule
